// File: rtl/latch_wr_seq_pkg.sv
// Shared types and constants for the latch write sequencer.
package latch_wr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OPEN  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DW_DEF        = 8;
   localparam int SETUP_CYC_DEF = 2;
   localparam int OPEN_CYC_DEF  = 3;
   localparam int HOLD_CYC_DEF  = 2;
   localparam int CNT_W         = 4;

endpackage

// File: rtl/latch_seq_timer.sv
// Phase timer: 4-bit down-counter, loaded on phase entry, holds at zero.
module latch_seq_timer
   import latch_wr_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/latch_wr_seq.sv
// Write sequencer for a transparent downstream latch: setup, open, hold, done.
// Optional readback compare is built when LATCH_WR_SEQ_RDBK_EN is defined.
//
// state | meaning
// IDLE  | ready for a request; done pulses here after a sequence
// SETUP | lat_d driven, lat_en low, SETUP_CYC cycles
// OPEN  | lat_en high, OPEN_CYC cycles
// HOLD  | lat_en low, lat_d held, HOLD_CYC cycles
module latch_wr_seq
   import latch_wr_seq_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int OPEN_CYC  = OPEN_CYC_DEF,
   parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [DW-1:0] lat_d,
   output logic          lat_en,
   output logic          busy,
   output logic          done
`ifdef LATCH_WR_SEQ_RDBK_EN
   ,
   input  logic [DW-1:0] lat_q,
   output logic          err
`endif
);

   if (DW < 1 || SETUP_CYC < 1 || SETUP_CYC > 15 || OPEN_CYC < 1 || OPEN_CYC > 15 ||
       HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_err
      $error("latch_wr_seq: DW must be >= 1 and phase lengths must be in 1..15");
   end

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   state_t           state;
   state_t           next_state;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             zero;
   logic             seq_end;

   latch_seq_timer u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (load),
      .load_val (load_val),
      .zero     (zero)
   );

   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_val   = '0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               next_state = SETUP;
               load       = 1'b1;
               load_val   = SETUP_LD;
            end
         end
         SETUP: begin
            if (zero) begin
               next_state = OPEN;
               load       = 1'b1;
               load_val   = OPEN_LD;
            end
         end
         OPEN: begin
            if (zero) begin
               next_state = HOLD;
               load       = 1'b1;
               load_val   = HOLD_LD;
            end
         end
         HOLD: begin
            if (zero) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign seq_end  = (state == HOLD) && zero;
   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

   // lat_en is decoded from next_state so it is a flop output aligned with OPEN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         lat_en <= 1'b0;
         lat_d  <= '0;
         done   <= 1'b0;
      end else begin
         state  <= next_state;
         lat_en <= (next_state == OPEN);
         done   <= seq_end;
         if (in_ready && in_valid) begin
            lat_d <= in_data;
         end
      end
   end

`ifdef LATCH_WR_SEQ_RDBK_EN
   logic first_hold;
   logic mismatch;
   logic err_q;

   // with HOLD_CYC=1 the first HOLD cycle is also the last, so compare live
   always_ff @(posedge clk) begin
      if (!rstn) begin
         first_hold <= 1'b0;
         mismatch   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         first_hold <= (state == OPEN) && (next_state == HOLD);
         if (first_hold) begin
            mismatch <= (lat_q != lat_d);
         end
         err_q <= seq_end && (first_hold ? (lat_q != lat_d) : mismatch);
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_latch_wr_seq.sv
// Scoreboard bench for latch_wr_seq: timeline reference model plus a latch model downstream.
module tb_latch_wr_seq;

   localparam int S = 2;
   localparam int O = 3;
   localparam int H = 2;
   localparam int L = S + O + H + 1;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] lat_d;
   logic       lat_en;
   logic       busy;
   logic       done;
   logic [7:0] q_lat;

   logic       m_rstn;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic [7:0] m_lat_d;
   logic       m_en;
   logic       m_busy;
   logic       m_done;

   typedef struct {
      logic [7:0] data;
      int         done_edge;
      logic       err;
   } exp_t;

   exp_t       sbq[$];
   int         n_chk = 0;
   int         n_err = 0;
   int         edge_n = 0;
   int         acc_e = 0;
   int         free_at = 0;
   bit         active = 1'b0;
   logic [7:0] exp_d = 8'h00;
   bit         bad_sel = 1'b0;
   bit         tx_bad = 1'b0;
   bit         min_done = 1'b0;

   always #5 clk = ~clk;

   // downstream transparent D-latch
   always_latch begin
      if (lat_en) q_lat <= lat_d;
   end

`ifdef LATCH_WR_SEQ_RDBK_EN
   logic [7:0] lat_q;
   logic       err;
   logic       m_err;
   assign lat_q = tx_bad ? 8'h00 : q_lat;
`endif

   latch_wr_seq #(.DW(8), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .lat_d    (lat_d),
      .lat_en   (lat_en),
      .busy     (busy),
      .done     (done)
`ifdef LATCH_WR_SEQ_RDBK_EN
      ,
      .lat_q    (lat_q),
      .err      (err)
`endif
   );

   latch_wr_seq #(.DW(8), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) dut_min (
      .clk      (clk),
      .rstn     (m_rstn),
      .in_valid (m_valid),
      .in_data  (m_data),
      .in_ready (m_ready),
      .lat_d    (m_lat_d),
      .lat_en   (m_en),
      .busy     (m_busy),
      .done     (m_done)
`ifdef LATCH_WR_SEQ_RDBK_EN
      ,
      .lat_q    (m_lat_d),
      .err      (m_err)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp_v);
      end
   endtask

   // one clock of stimulus; the reference model decides accepts from elapsed time alone
   task automatic drive(input bit v, input logic [7:0] d, input bit r);
      exp_t e;
      in_valid = v;
      in_data  = d;
      rstn     = r;
      @(posedge clk);
      #1;
      edge_n++;
      if (!r) begin
         active  = 1'b0;
         exp_d   = 8'h00;
         sbq.delete();
         free_at = edge_n + 1;
      end else if (v && edge_n >= free_at) begin
         active  = 1'b1;
         acc_e   = edge_n;
         exp_d   = d;
         tx_bad  = bad_sel;
         free_at = edge_n + L;
         e.data      = d;
         e.done_edge = edge_n + L - 1;
         e.err       = bad_sel && (d != 8'h00);
         sbq.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      int   k;
      bit   e_rdy;
      bit   e_en;
      bit   e_done;
      exp_t e;
      if (edge_n > 0) begin
         k      = edge_n - acc_e;
         e_rdy  = !active || (k >= L - 1);
         e_en   = active && (k >= S) && (k < S + O);
         e_done = active && (k == L - 1);
         chk("in_ready", 32'(in_ready), 32'(e_rdy));
         chk("busy", 32'(busy), 32'(!e_rdy));
         chk("lat_en", 32'(lat_en), 32'(e_en));
         chk("lat_d", 32'(lat_d), 32'(exp_d));
         chk("done", 32'(done), 32'(e_done));
`ifdef LATCH_WR_SEQ_RDBK_EN
         if (!done) chk("err_idle", 32'(err), 32'(0));
`endif
         if (done) begin
            if (sbq.size() == 0) begin
               chk("done_unexpected", 32'(done), 32'(0));
            end else begin
               e = sbq.pop_front();
               chk("done_edge", 32'(edge_n), 32'(e.done_edge));
               chk("latch_q", 32'(q_lat), 32'(e.data));
`ifdef LATCH_WR_SEQ_RDBK_EN
               chk("err", 32'(err), 32'(e.err));
`endif
            end
         end
      end
   end

   initial begin
      int en_cnt;
      int done_k;
      en_cnt  = 0;
      done_k  = 0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_rstn  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_rstn  = 1'b1;
      m_valid = 1'b1;
      m_data  = 8'h01;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_data  = 8'hEE;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (m_en) en_cnt++;
         if (m_done && done_k == 0) done_k = k;
         if (k == 2) chk("min_en_cycle2", 32'(m_en), 32'(1));
         if (k == 4) chk("min_ready_done", 32'(m_ready), 32'(1));
         chk("min_lat_d", 32'(m_lat_d), 32'h01);
      end
      chk("min_en_count", 32'(en_cnt), 32'(1));
      chk("min_done_cycle", 32'(done_k), 32'(4));
      min_done = 1'b1;
   end

   initial begin
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'hA5, 1'b1);
      repeat (9) drive(1'b0, 8'h00, 1'b1);
      drive(1'b1, 8'h3C, 1'b1);
      repeat (8) drive(1'b1, 8'h7E, 1'b1);
      repeat (9) drive(1'b0, 8'h00, 1'b1);
      drive(1'b1, 8'h11, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b1);
      repeat (3) drive(1'b1, 8'hFF, 1'b1);
      repeat (6) drive(1'b0, 8'h00, 1'b1);
      drive(1'b1, 8'h11, 1'b1);
      repeat (3) drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h22, 1'b1);
      repeat (9) drive(1'b0, 8'h00, 1'b1);
      bad_sel = 1'b1;
      drive(1'b1, 8'h5A, 1'b1);
      repeat (8) drive(1'b0, 8'h00, 1'b1);
      bad_sel = 1'b0;
      drive(1'b1, 8'hC3, 1'b1);
      repeat (9) drive(1'b0, 8'h00, 1'b1);
      repeat (800) begin
         bad_sel = ($urandom_range(0, 3) == 0);
         drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) != 0);
      end
      repeat (L + 2) drive(1'b0, 8'h00, 1'b1);
      chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
      chk("min_params_ran", 32'(min_done), 32'(1));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
